// File: rtl/controlador_partida_pkg.sv
// Shared definitions for the naval-battle game sequencer: state and result
// encodings, board geometry and the cell index helper.
package controlador_partida_pkg;

  localparam int LINHAS_MAPA  = 7;
  localparam int COLUNAS_MAPA = 5;
  localparam int N_CELULAS    = LINHAS_MAPA * COLUNAS_MAPA;

  typedef enum logic [2:0] {
    DESLIGADO  = 3'd0,
    PREPARACAO = 3'd1,
    CONTANDO   = 3'd2,
    PRONTO     = 3'd3,
    ATAQUE     = 3'd4,
    VITORIA    = 3'd5,
    DERROTA    = 3'd6
  } estado_t;

  typedef enum logic [2:0] {
    NENHUM   = 3'd0,
    AGUA     = 3'd1,
    ACERTO   = 3'd2,
    REPETIDO = 3'd3,
    INVALIDO = 3'd4
  } ultimo_t;

  // Column-major cell index; the result only addresses the map for in-range coordinates.
  function automatic logic [5:0] indice_celula(input logic [2:0] linha, input logic [2:0] coluna);
    logic [5:0] v_idx;
    v_idx = 6'(coluna) * 6'(LINHAS_MAPA) + 6'(linha);
    return v_idx;
  endfunction

endpackage

// File: rtl/controlador_partida_contador.sv
// Sequential popcount of the locked map: one cell per cycle, 35 cycles,
// with a one-cycle done flag once the final total is registered.
module contador_navios
  import controlador_partida_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        limpa,
  input  logic        inicia,
  input  logic [34:0] mapa,
  output logic        fim,
  output logic [5:0]  total
);

  logic [5:0] r_idx;
  logic [5:0] r_total;
  logic       r_ativo;
  logic       r_fim;

  // Scan index, running total and end flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_idx   <= 6'd0;
      r_total <= 6'd0;
      r_ativo <= 1'b0;
      r_fim   <= 1'b0;
    end else if (limpa) begin
      r_idx   <= 6'd0;
      r_total <= 6'd0;
      r_ativo <= 1'b0;
      r_fim   <= 1'b0;
    end else if (inicia) begin
      r_idx   <= 6'd0;
      r_total <= 6'd0;
      r_ativo <= 1'b1;
      r_fim   <= 1'b0;
    end else if (r_ativo) begin
      r_total <= r_total + {5'd0, mapa[r_idx]};
      if (r_idx == 6'(N_CELULAS - 1)) begin
        r_ativo <= 1'b0;
        r_fim   <= 1'b1;
      end else begin
        r_idx   <= r_idx + 6'd1;
        r_fim   <= 1'b0;
      end
    end else begin
      r_fim <= 1'b0;
    end
  end

  assign fim   = r_fim;
  assign total = r_total;

endmodule

// File: rtl/controlador_partida.sv
// Game sequencer for the naval-battle board: state machine, map lock,
// shot/hit bookkeeping, end-of-game judgement and status LEDs.
module controlador_partida #(
  parameter int MAX_TIROS = 20,
  parameter int LINHAS    = 7,
  parameter int COLUNAS   = 5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        liga,
  input  logic        modo,
  input  logic        confirmar,
  input  logic [2:0]  coord_linha,
  input  logic [2:0]  coord_coluna,
  input  logic [34:0] mapa_sel,
  output logic [2:0]  estado,
  output logic [34:0] matriz_tiro,
  output logic [34:0] matriz_acerto,
  output logic [5:0]  tiros,
  output logic [5:0]  acertos,
  output logic [5:0]  total_navio,
  output logic        evento,
  output logic        LED_R,
  output logic        LED_G,
  output logic        LED_B
);
  import controlador_partida_pkg::*;

  estado_t     r_estado, w_estado_n;
  ultimo_t     r_ultimo, w_ultimo_n;
  logic [34:0] r_mapa_trav, w_mapa_n;
  logic [34:0] r_tiro, w_tiro_n;
  logic [34:0] r_acerto, w_acerto_n;
  logic [5:0]  r_tiros, w_tiros_n;
  logic [5:0]  r_acertos, w_acertos_n;
  logic        r_evento, w_evento_n;
  logic        r_led_r, r_led_g, r_led_b;
  logic        w_led_r, w_led_g, w_led_b;
  logic        w_inicia, w_limpa, w_fim, w_rejeita;
  logic [5:0]  w_total;
  logic        w_valida, w_repetido;
  logic [5:0]  w_idx;

  assign w_valida   = (coord_linha < 3'(LINHAS)) && (coord_coluna < 3'(COLUNAS));
  assign w_idx      = w_valida ? indice_celula(coord_linha, coord_coluna) : 6'd0;
  assign w_repetido = w_valida ? r_tiro[w_idx] : 1'b0;

  contador_navios u_contador (
    .clock   (clock),
    .reset_n (reset_n),
    .limpa   (w_limpa),
    .inicia  (w_inicia),
    .mapa    (r_mapa_trav),
    .fim     (w_fim),
    .total   (w_total)
  );

  // Next state, shot judgement and next LED values; liga then modo override confirmar.
  always_comb begin
    w_estado_n  = r_estado;
    w_ultimo_n  = r_ultimo;
    w_mapa_n    = r_mapa_trav;
    w_tiro_n    = r_tiro;
    w_acerto_n  = r_acerto;
    w_tiros_n   = r_tiros;
    w_acertos_n = r_acertos;
    w_evento_n  = 1'b0;
    w_inicia    = 1'b0;
    w_limpa     = 1'b0;
    w_rejeita   = 1'b0;
    w_led_r     = 1'b0;
    w_led_g     = 1'b0;
    w_led_b     = 1'b0;

    if (!liga) begin
      w_estado_n = DESLIGADO;
    end else begin
      case (r_estado)
        DESLIGADO: w_estado_n = PREPARACAO;
        PREPARACAO: begin
          if (confirmar) begin
            w_estado_n = CONTANDO;
            w_mapa_n   = mapa_sel;
            w_inicia   = 1'b1;
          end else begin
            w_estado_n = PREPARACAO;
          end
        end
        CONTANDO: begin
          if (w_fim) begin
            if (w_total == 6'd0) begin
              w_estado_n = PREPARACAO;
              w_rejeita  = 1'b1;
            end else begin
              w_estado_n = PRONTO;
            end
          end else begin
            w_estado_n = CONTANDO;
          end
        end
        PRONTO: begin
          if (modo) begin
            w_estado_n = ATAQUE;
          end else if (confirmar) begin
            w_estado_n = CONTANDO;
            w_mapa_n   = mapa_sel;
            w_inicia   = 1'b1;
          end else begin
            w_estado_n = PRONTO;
          end
        end
        ATAQUE: begin
          if (!modo) begin
            w_estado_n = PREPARACAO;
          end else if (confirmar) begin
            w_evento_n = 1'b1;
            if (!w_valida) begin
              w_ultimo_n = INVALIDO;
            end else if (w_repetido) begin
              w_ultimo_n = REPETIDO;
            end else begin
              w_tiro_n[w_idx] = 1'b1;
              w_tiros_n       = r_tiros + 6'd1;
              if (r_mapa_trav[w_idx]) begin
                w_acerto_n[w_idx] = 1'b1;
                w_acertos_n       = r_acertos + 6'd1;
                w_ultimo_n        = ACERTO;
              end else begin
                w_ultimo_n = AGUA;
              end
              // The winning hit beats the limit shot when both land together.
              if (w_acertos_n == w_total) begin
                w_estado_n = VITORIA;
              end else if (w_tiros_n == 6'(MAX_TIROS)) begin
                w_estado_n = DERROTA;
              end else begin
                w_estado_n = ATAQUE;
              end
            end
          end else begin
            w_estado_n = ATAQUE;
          end
        end
        VITORIA, DERROTA: begin
          if (!modo) begin
            w_estado_n = PREPARACAO;
          end else begin
            w_estado_n = r_estado;
          end
        end
        default: w_estado_n = DESLIGADO;
      endcase
    end

    if (w_estado_n == DESLIGADO || w_estado_n == PREPARACAO) begin
      w_limpa     = 1'b1;
      w_mapa_n    = 35'd0;
      w_tiro_n    = 35'd0;
      w_acerto_n  = 35'd0;
      w_tiros_n   = 6'd0;
      w_acertos_n = 6'd0;
      w_ultimo_n  = NENHUM;
    end else begin
      w_limpa = 1'b0;
    end

    case (w_estado_n)
      ATAQUE: begin
        w_led_g = (w_ultimo_n == ACERTO);
        w_led_r = (w_ultimo_n == AGUA);
        w_led_b = (w_ultimo_n == REPETIDO) || (w_ultimo_n == INVALIDO);
      end
      PREPARACAO, PRONTO: w_led_b = 1'b1;
      VITORIA:            w_led_g = 1'b1;
      DERROTA:            w_led_r = 1'b1;
      default: begin
        w_led_r = 1'b0;
        w_led_g = 1'b0;
        w_led_b = 1'b0;
      end
    endcase
    w_led_b = w_led_b | w_rejeita;
  end

  // State, game record and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_estado    <= DESLIGADO;
      r_ultimo    <= NENHUM;
      r_mapa_trav <= 35'd0;
      r_tiro      <= 35'd0;
      r_acerto    <= 35'd0;
      r_tiros     <= 6'd0;
      r_acertos   <= 6'd0;
      r_evento    <= 1'b0;
      r_led_r     <= 1'b0;
      r_led_g     <= 1'b0;
      r_led_b     <= 1'b0;
    end else begin
      r_estado    <= w_estado_n;
      r_ultimo    <= w_ultimo_n;
      r_mapa_trav <= w_mapa_n;
      r_tiro      <= w_tiro_n;
      r_acerto    <= w_acerto_n;
      r_tiros     <= w_tiros_n;
      r_acertos   <= w_acertos_n;
      r_evento    <= w_evento_n;
      r_led_r     <= w_led_r;
      r_led_g     <= w_led_g;
      r_led_b     <= w_led_b;
    end
  end

  assign estado        = r_estado;
  assign matriz_tiro   = r_tiro;
  assign matriz_acerto = r_acerto;
  assign tiros         = r_tiros;
  assign acertos       = r_acertos;
  assign total_navio   = w_total;
  assign evento        = r_evento;
  assign LED_R         = r_led_r;
  assign LED_G         = r_led_g;
  assign LED_B         = r_led_b;

endmodule

// File: tb/tb_controlador_partida.sv
// Directed bench: two sequencers share stimulus, one with the default shot
// limit and one limited to three shots.
module tb_controlador_partida;

  logic        clock = 1'b0;
  logic        reset_n, liga, modo, confirmar;
  logic [2:0]  coord_linha, coord_coluna;
  logic [34:0] mapa_sel;

  logic [2:0]  a_estado, b_estado;
  logic [34:0] a_mt, a_ma, b_mt, b_ma;
  logic [5:0]  a_tiros, a_acertos, a_total, b_tiros, b_acertos, b_total;
  logic        a_evento, a_r, a_g, a_b, b_evento, b_r, b_g, b_b;

  int total_cnt = 0;
  int bad_cnt   = 0;

  controlador_partida dut_a (
    .clock(clock), .reset_n(reset_n), .liga(liga), .modo(modo), .confirmar(confirmar),
    .coord_linha(coord_linha), .coord_coluna(coord_coluna), .mapa_sel(mapa_sel),
    .estado(a_estado), .matriz_tiro(a_mt), .matriz_acerto(a_ma), .tiros(a_tiros),
    .acertos(a_acertos), .total_navio(a_total), .evento(a_evento),
    .LED_R(a_r), .LED_G(a_g), .LED_B(a_b)
  );

  controlador_partida #(.MAX_TIROS(3)) dut_b (
    .clock(clock), .reset_n(reset_n), .liga(liga), .modo(modo), .confirmar(confirmar),
    .coord_linha(coord_linha), .coord_coluna(coord_coluna), .mapa_sel(mapa_sel),
    .estado(b_estado), .matriz_tiro(b_mt), .matriz_acerto(b_ma), .tiros(b_tiros),
    .acertos(b_acertos), .total_navio(b_total), .evento(b_evento),
    .LED_R(b_r), .LED_G(b_g), .LED_B(b_b)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fire(input logic [2:0] l, input logic [2:0] c);
    coord_linha  = l;
    coord_coluna = c;
    confirmar    = 1'b1;
    tick();
    confirmar    = 1'b0;
  endtask

  task automatic lock_map(input logic [34:0] m);
    mapa_sel  = m;
    confirmar = 1'b1;
    tick();
    confirmar = 1'b0;
    repeat (36) tick();
  endtask

  initial begin
    logic [34:0] m4, m1;
    m4 = 35'd0;
    m4[0] = 1'b1; m4[9] = 1'b1; m4[20] = 1'b1; m4[34] = 1'b1;
    m1 = 35'd1;

    reset_n = 1'b0; liga = 1'b0; modo = 1'b0; confirmar = 1'b0;
    coord_linha = 3'd0; coord_coluna = 3'd0; mapa_sel = 35'd0;
    repeat (3) tick();
    check_eq("rst_estado", a_estado, 3'd0);
    check_eq("rst_tiros", a_tiros, 6'd0);
    check_eq("rst_leds", {a_r, a_g, a_b, a_evento}, 4'd0);

    reset_n = 1'b1; liga = 1'b1;
    tick();
    check_eq("prep_estado", a_estado, 3'd1);
    check_eq("prep_ledb", a_b, 1'b1);

    // Lock a 4-ship map and time the scan.
    mapa_sel = m4; confirmar = 1'b1;
    tick();
    confirmar = 1'b0;
    check_eq("scan_start", a_estado, 3'd2);
    repeat (35) tick();
    check_eq("scan_last", a_estado, 3'd2);
    tick();
    check_eq("pronto_36", a_estado, 3'd3);
    check_eq("total4", a_total, 6'd4);

    modo = 1'b1;
    tick();
    check_eq("ataque", a_estado, 3'd4);
    check_eq("ataque_leds_off", {a_r, a_g, a_b}, 3'd0);

    fire(3'd2, 3'd1);
    check_eq("hit_tiros", a_tiros, 6'd1);
    check_eq("hit_acertos", a_acertos, 6'd1);
    check_eq("hit_mt9", a_mt, 35'h200);
    check_eq("hit_ma9", a_ma, 35'h200);
    check_eq("hit_leds", {a_r, a_g, a_b, a_evento}, 4'b0101);
    tick();
    check_eq("evento_pulse", a_evento, 1'b0);

    fire(3'd2, 3'd1);
    check_eq("rep_tiros", a_tiros, 6'd1);
    check_eq("rep_leds", {a_r, a_g, a_b, a_evento}, 4'b0011);

    fire(3'd7, 3'd0);
    check_eq("inv_linha", {a_tiros, a_b, a_evento}, {6'd1, 2'b11});
    fire(3'd0, 3'd5);
    check_eq("inv_coluna", {a_tiros, a_acertos, a_b}, {6'd1, 6'd1, 1'b1});

    fire(3'd1, 3'd0);
    check_eq("miss_ledr", {a_r, a_g, a_b}, 3'b100);
    fire(3'd2, 3'd0);
    check_eq("b_derrota", b_estado, 3'd6);
    check_eq("b_derrota_r", b_r, 1'b1);
    for (int i = 3; i < 7; i++) fire(3'(i), 3'd0);
    check_eq("a_tiros7", {a_estado, a_tiros, a_acertos}, {3'd4, 6'd7, 6'd1});
    check_eq("b_frozen", b_tiros, 6'd3);

    // Asynchronous reset in the middle of the attack.
    reset_n = 1'b0;
    #2;
    check_eq("mid_rst_estado", a_estado, 3'd0);
    check_eq("mid_rst_cnt", {a_tiros, a_acertos, a_total}, 18'd0);
    check_eq("mid_rst_mt", {a_mt, a_ma}, 70'd0);
    check_eq("mid_rst_out", {a_r, a_g, a_b, a_evento}, 4'd0);

    modo = 1'b0;
    reset_n = 1'b1;
    tick();
    mapa_sel = 35'd0; confirmar = 1'b1;
    tick();
    confirmar = 1'b0;
    repeat (35) tick();
    check_eq("empty_scan_ledb", {a_estado, a_b}, {3'd2, 1'b0});
    tick();
    check_eq("empty_reject", {a_estado, a_b, a_total}, {3'd1, 1'b1, 6'd0});

    // Three-shot limit with a single-ship map.
    lock_map(m1);
    check_eq("b_pronto1", {b_estado, b_total}, {3'd3, 6'd1});
    modo = 1'b1;
    tick();
    fire(3'd1, 3'd0);
    fire(3'd2, 3'd0);
    check_eq("b_two_miss", {b_estado, b_tiros}, {3'd4, 6'd2});
    fire(3'd3, 3'd0);
    check_eq("b_loss", {b_estado, b_tiros, b_r, b_g}, {3'd6, 6'd3, 2'b10});
    tick();
    check_eq("b_loss_steady", {b_estado, b_r}, {3'd6, 1'b1});
    fire(3'd0, 3'd0);
    check_eq("b_loss_ignore", {b_estado, b_tiros, b_acertos}, {3'd6, 6'd3, 6'd0});
    check_eq("a_win4", a_estado, 3'd5);

    modo = 1'b0;
    tick();
    check_eq("b_back_prep", {b_estado, b_tiros, b_mt}, {3'd1, 6'd0, 35'd0});
    lock_map(m1);
    modo = 1'b1;
    tick();
    fire(3'd1, 3'd0);
    fire(3'd2, 3'd0);
    fire(3'd0, 3'd0);
    check_eq("b_win_prio", {b_estado, b_tiros, b_acertos, b_g, b_r}, {3'd5, 6'd3, 6'd1, 2'b10});

    modo = 1'b0;
    tick();
    lock_map(m1);
    modo = 1'b1;
    tick();
    modo = 1'b0;
    fire(3'd1, 3'd0);
    check_eq("modo_drop_shot", {b_estado, b_tiros, b_mt, b_evento}, {3'd1, 6'd0, 35'd0, 1'b0});

    liga = 1'b0;
    tick();
    check_eq("liga_off", {a_estado, b_estado}, 6'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/controlador_partida.md
# controlador_partida

Game sequencer for the naval-battle board. It sits between the switch/button inputs and the map, attack and display datapath. It owns the game state machine, locks the selected map, counts its ship cells and keeps the shot/hit record. It judges every attack, enforces a shot limit and drives the status LEDs and state outputs consumed by the LED-matrix and 7-segment blocks.

## Interface
Parameters:
- MAX_TIROS, default 20: shots allowed per match, range 1..35.
- LINHAS, default 7: rows per column.
- COLUNAS, default 5: columns.

Ports:
- clock  in  1: system clock (divided clock domain); single clock, all logic rising-edge.
- reset_n  in  1: asynchronous, active-low reset.
- liga  in  1: power switch (ch7), level.
- modo  in  1: 0 = preparation, 1 = attack (ch6), level.
- confirmar  in  1: one-cycle pulse from level_to_pulse.
- coord_linha  in  3: attack row, valid 0..6.
- coord_coluna  in  3: attack column, valid 0..4.
- mapa_sel  in  35: candidate map, bit index = coluna*7 + linha, 1 = ship.
- estado  out  3: encoded state (see Structure).
- matriz_tiro  out  35: cells already shot.
- matriz_acerto  out  35: shot cells that were ships.
- tiros  out  6: shots taken.
- acertos  out  6: hits.
- total_navio  out  6: ship cells in the locked map.
- evento  out  1: one-cycle pulse when an attack is judged, including invalid or repeated attacks.
- LED_R, LED_G, LED_B  out  1 each: status.

## Operation
- States: DESLIGADO, PREPARACAO, CONTANDO, PRONTO, ATAQUE, VITORIA, DERROTA.
- liga=0 forces DESLIGADO from any state next cycle. This clears all counters and matrices and unlocks the map.
- DESLIGADO -> PREPARACAO when liga=1.
- PREPARACAO: on confirmar, capture mapa_sel into mapa_trav, clear the scan counter and go to CONTANDO.
- CONTANDO: add one bit of mapa_trav per cycle into total_navio, for indexes 0..34, which takes 35 cycles. confirmar and modo are ignored here.
  - Scan ends with total_navio=0: return to PREPARACAO and pulse LED_B for one cycle (empty map rejected).
  - Scan ends with total_navio>0: go to PRONTO.
- PRONTO: modo=1 moves to ATAQUE. confirmar re-locks the map and returns to CONTANDO.
- ATAQUE, on confirmar:
  - Out-of-range coordinate: evento=1, ultimo=INVALIDO, no counter change.
  - Cell already shot: evento=1, ultimo=REPETIDO, no counter change.
  - Otherwise: set the matriz_tiro bit and increment tiros. If the cell is a ship, also set the matriz_acerto bit, increment acertos and set ultimo=ACERTO; else ultimo=AGUA.
- ATAQUE end of game, evaluated on the updated counters in the same cycle:
  - acertos == total_navio -> VITORIA. Win has priority when the last shot is both the limit shot and the winning hit.
  - else tiros == MAX_TIROS -> DERROTA.
- ATAQUE with modo=0: back to PREPARACAO. Clears shots, hits and the lock.
- VITORIA/DERROTA are terminal; confirmar is ignored. modo=0 -> PREPARACAO with the same clears.
- LEDs:
  - ATAQUE: G = ACERTO, R = AGUA, B = INVALIDO/REPETIDO, all off before the first shot.
  - VITORIA: G steady. DERROTA: R steady.
  - PREPARACAO/PRONTO: B steady. All other states: off.
- Counter widths: 6 bits. They cannot overflow: tiros <= MAX_TIROS <= 35.

## Timing
- Reset values:
  - estado = DESLIGADO.
  - matriz_tiro, matriz_acerto, tiros, acertos, total_navio = 0.
  - evento = 0; LEDs = 0; ultimo = NENHUM.
- Every output is registered.
- Attack latency: confirmar sampled at edge N; matrices, counters, evento and LEDs are valid after edge N+1. The end-game state is valid after edge N+1 as well, in the same cycle.
- Map lock: confirmar at edge N; CONTANDO occupies edges N+1..N+35; PRONTO or PREPARACAO follows at N+36.
- Reset or liga=0 mid-scan or mid-attack aborts with no partial update.
- confirmar coinciding with liga=0 or modo=0: the state change wins and the shot is discarded.

## Structure
- Shared package: state encoding (DESLIGADO=0 … DERROTA=6), ultimo codes (NENHUM, AGUA, ACERTO, REPETIDO, INVALIDO), LINHAS/COLUNAS constants, and the index function coluna*LINHAS+linha.
- One sub-module: contador_navios, the sequential 35-cycle popcount with start, done and total signals.

## Test plan
- Reset mid-ATAQUE with tiros=7 -> every output returns to its reset value and estado=DESLIGADO.
- Lock a map with 4 ship cells -> PRONTO exactly 36 cycles after confirmar, total_navio=4. Lock an all-zero map -> PREPARACAO and a one-cycle LED_B pulse.
- In ATAQUE, fire (linha 2, coluna 1) on a ship -> tiros=1, acertos=1, bit 9 set in both matrices, LED_G=1. Fire the same cell again -> counters unchanged, LED_B=1, evento pulses.
- Fire at coord_linha=7 or coord_coluna=5 -> INVALIDO, no counter change.
- MAX_TIROS=3, map with 1 ship: three misses -> DERROTA with LED_R steady. Separately, 2 misses then a hit -> VITORIA, because win takes priority.
- modo dropped to 0 in ATAQUE in the same cycle as confirmar -> PREPARACAO, tiros=0, the shot is discarded.
